// File: rtl/weight_dot_pkg.sv
// Shared types and helpers for the weight dot-product engine.
// WEIGHT_DOT_SAT_EN selects saturating narrowing; undefined gives wrap.
package weight_dot_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int acc_width(input int data_w, input int w_w, input int n);
    return data_w + w_w + $clog2(n);
  endfunction

  // Works on a 64-bit container so any accumulator up to 64 bits can use it;
  // the caller keeps the low out_w bits of the result.
  function automatic logic signed [63:0] narrow(input logic signed [63:0] x,
                                                input int shift, input int out_w);
    logic signed [63:0] s;
`ifdef WEIGHT_DOT_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
`endif
    s = x >>> shift;
`ifdef WEIGHT_DOT_SAT_EN
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    return (s <<< (64 - out_w)) >>> (64 - out_w);
`endif
  endfunction

endpackage

// File: rtl/weight_dot_engine_narrow.sv
// Combinational arithmetic shift plus wrap/saturate from accumulator to result
// width. Saturation is selected by WEIGHT_DOT_SAT_EN.
module weight_dot_narrow
  import weight_dot_pkg::*;
#(
  parameter int IN_W  = 34,
  parameter int OUT_W = 24,
  parameter int SHIFT = 0
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);

  logic signed [63:0] x_ext;

  function automatic logic [OUT_W-1:0] narrow_out(input logic signed [63:0] v);
    return OUT_W'(narrow(v, SHIFT, OUT_W));
  endfunction

  assign x_ext = 64'($signed(x));
  assign y     = narrow_out(x_ext);

endmodule

// File: rtl/weight_dot_engine.sv
// Streams N samples against ROM weights and emits one narrowed dot product per
// frame. WEIGHT_DOT_SAT_EN (in weight_dot_pkg) switches narrowing to saturation.
module weight_dot_engine
  import weight_dot_pkg::*;
#(
  parameter int          N        = 1024,
  parameter int          DATA_W   = 16,
  parameter int          W_W      = 8,
  parameter int          ACC_W    = acc_width(DATA_W, W_W, N),
  parameter int          OUT_W    = 24,
  parameter int          SHIFT    = 0,
  parameter logic [31:0] BASE_ADR = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       w_adr,
  input  logic [W_W-1:0]    w_data,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int IDX_W = $clog2(N);
  localparam int PRD_W = DATA_W + W_W;

  state_t state, state_nx;

  logic [IDX_W-1:0]        idx_p1;
  logic signed [ACC_W-1:0] acc_p1;
  logic [OUT_W-1:0]        m_data_p1;
  logic                    m_vld_p1;

  logic                    xfer;
  logic                    last;
  logic signed [PRD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0] sum_p0;
  logic [OUT_W-1:0]        res_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    s_ready  = 1'b0;
    w_adr    = BASE_ADR;
    xfer     = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        w_adr   = BASE_ADR + 32'(idx_p1);
        xfer    = s_valid;
        last    = s_valid && (idx_p1 == IDX_W'(N - 1));
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (m_vld_p1 && m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage 0: full-precision product of the accepted sample and the ROM word
  assign prod_p0 = $signed(s_data) * $signed(w_data);
  assign sum_p0  = acc_p1 + ACC_W'(prod_p0);

  weight_dot_narrow #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_narrow (
    .x (sum_p0),
    .y (res_p0)
  );

  // Stage 1: accumulator, index and the held frame result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_p1    <= '0;
      acc_p1    <= '0;
      m_data_p1 <= '0;
      m_vld_p1  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        idx_p1 <= '0;
        acc_p1 <= '0;
      end
      if (xfer) begin
        if (last) begin
          idx_p1    <= '0;
          m_data_p1 <= res_p0;
          m_vld_p1  <= 1'b1;
        end else begin
          idx_p1 <= idx_p1 + IDX_W'(1);
          acc_p1 <= sum_p0;
        end
      end
      if (state == DONE && m_ready) m_vld_p1 <= 1'b0;
    end
  end

  assign m_data  = m_data_p1;
  assign m_valid = m_vld_p1;

endmodule

// File: tb/tb_weight_dot_engine.sv
// Scoreboard bench for weight_dot_engine: frame results are predicted from the
// sample/weight arrays with plain arithmetic and checked by a separate monitor.
module tb_weight_dot_engine;

  localparam int          N        = 4;
  localparam int          DATA_W   = 16;
  localparam int          W_W      = 8;
  localparam int          OUT_W    = 8;
  localparam int          SHIFT    = 0;
  localparam logic [31:0] BASE     = 32'h10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       w_adr;
  logic [W_W-1:0]    w_data;
  logic [OUT_W-1:0]  m_data;
  logic              m_valid;
  logic              m_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  logic signed [W_W-1:0]    cur_w [N];
  logic signed [DATA_W-1:0] cur_s [N];
  longint                   exp_q [$];

  weight_dot_engine #(
    .N(N), .DATA_W(DATA_W), .W_W(W_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .BASE_ADR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .w_adr(w_adr), .w_data(w_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Behavioural weight ROM, combinational read
  always_comb begin
    longint off;
    off = longint'(w_adr) - longint'(BASE);
    w_data = '0;
    if (off >= 0 && off < N) w_data = cur_w[int'(off)];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint model();
    longint sum, v, span;
    sum = 0;
    for (int k = 0; k < N; k++) sum += longint'(cur_s[k]) * longint'(cur_w[k]);
    v = sum >>> SHIFT;
    span = longint'(1) << OUT_W;
`ifdef WEIGHT_DOT_SAT_EN
    if (v > span / 2 - 1) v = span / 2 - 1;
    if (v < -(span / 2)) v = -(span / 2);
`else
    v = ((v + span / 2) % span + span) % span - span / 2;
`endif
    return v;
  endfunction

  // Monitor: compares every presented result against the queue head
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", m_valid, 0);
      end else begin
        chk("m_data", longint'($signed(m_data)), exp_q[0]);
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit push);
    chk("idle_busy", busy, 0);
    chk("idle_w_adr", w_adr, BASE);
    start = 1'b1;
    if (push) exp_q.push_back(model());
    tick();
    start = 1'b0;
    chk("run_busy", busy, 1);
  endtask

  task automatic feed(input int gap, input bit rnd, input int count);
    int g;
    for (int k = 0; k < count; k++) begin
      g = rnd ? int'($urandom_range(0, 2)) : gap;
      for (int j = 0; j < g; j++) begin
        s_valid = 1'b0;
        s_data  = DATA_W'($urandom);
        chk("gap_w_adr", w_adr, BASE + k);
        tick();
      end
      s_valid = 1'b1;
      s_data  = cur_s[k];
      chk("w_adr", w_adr, BASE + k);
      chk("s_ready_run", s_ready, 1);
      if (k == N - 1) chk("m_valid_early", m_valid, 0);
      tick();
    end
    s_valid = 1'b0;
    if (count == N) chk("m_valid_latency", m_valid, 1);
  endtask

  task automatic finish_frame();
    chk("done_s_ready", s_ready, 0);
    tick();
    chk("back_to_idle", busy, 0);
    chk("m_valid_clear", m_valid, 0);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 40) begin
      m_ready = ($urandom_range(0, 3) != 0) || (c > 30);
      tick();
      c++;
    end
    chk("idle_timeout", busy, 0);
    m_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_w_adr", w_adr, BASE);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic frame
    cur_w = '{8'sd1, -8'sd2, 8'sd3, -8'sd4};
    cur_s = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
    chk("model_basic", model(), -100);
    start_frame(1);
    feed(0, 0, N);
    finish_frame();

    // Gapped input
    start_frame(1);
    feed(3, 0, N);
    finish_frame();

    // Output backpressure with a stray start
    m_ready = 1'b0;
    start_frame(1);
    feed(0, 0, N);
    for (int c = 0; c < 5; c++) begin
      chk("bp_m_valid", m_valid, 1);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_w_adr", w_adr, BASE);
      start = (c == 2);
      tick();
    end
    start = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("bp_idle", busy, 0);
    chk("bp_m_valid_clear", m_valid, 0);
    tick();
    chk("bp_start_ignored", busy, 0);

    // Reset mid-frame
    start_frame(0);
    feed(0, 0, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_w_adr", w_adr, BASE);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", busy, 0);
    start_frame(1);
    feed(0, 0, N);
    finish_frame();

    // Narrowing, positive then negative, back-to-back after each handshake
    cur_w = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
    cur_s = '{16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000};
`ifdef WEIGHT_DOT_SAT_EN
    chk("model_pos", model(), 127);
`else
    chk("model_pos", model(), 96);
`endif
    start_frame(1);
    feed(0, 0, N);
    finish_frame();
    cur_s = '{-16'sd1000, -16'sd1000, -16'sd1000, -16'sd1000};
    start_frame(1);
    feed(0, 0, N);
    finish_frame();
    cur_w = '{8'sd1, -8'sd2, 8'sd3, -8'sd4};
    cur_s = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
    start_frame(1);
    feed(0, 0, N);
    finish_frame();

    // Randomized frames with random gaps and backpressure
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < N; k++) begin
        cur_w[k] = W_W'($urandom);
        cur_s[k] = DATA_W'($urandom);
      end
      if (f % 5 == 0) begin
        for (int k = 0; k < N; k++) begin
          cur_w[k] = (f % 10 == 0) ? -8'sd128 : 8'sd127;
          cur_s[k] = -16'sd32768;
        end
      end
      repeat ($urandom_range(0, 2)) tick();
      start_frame(1);
      feed(0, 1, N);
      wait_idle();
    end

    for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
